usb_rcv_ctrl: RTL and testbench



---
 rtl/usb_rcv_ctrl.sv | 146 ++++++++++++++
 tb/tb_usb_rcv_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rcv_ctrl.sv
// Receive control FSM for the USB receiver: frames sampled bits into bytes,
// validates SYNC, strobes the RX FIFO once per payload byte and flags framing errors.
module usb_rcv_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64,
    localparam int        CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          d_edge,
    input  logic          eop,
    input  logic          shift_enable,
    input  logic [7:0]    rcv_data,
    output logic          rcving,
    output logic          w_enable,
    output logic          r_error,
    output logic [CW-1:0] byte_cnt,
    output logic [3:0]    state_dbg
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SYNC_RX  = 4'd1,
        SYNC_CHK = 4'd2,
        DATA_RX  = 4'd3,
        STORE    = 4'd4,
        EOP_WAIT = 4'd5,
        ERR_WAIT = 4'd6,
        ERR_EOP  = 4'd7,
        EIDLE    = 4'd8
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

    state_t     state;
    state_t     next_state;
    logic [2:0] bit_cnt;
    logic       pkt_start;
    logic       counting;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pkt_start  = 1'b0;
        case (state)
            IDLE: begin
                if (d_edge) begin
                    next_state = SYNC_RX;
                    pkt_start  = 1'b1;
                end
            end
            SYNC_RX: begin
                if (shift_enable && eop)
                    next_state = ERR_EOP;
                else if (shift_enable && bit_cnt == 3'd7)
                    next_state = SYNC_CHK;
            end
            SYNC_CHK: begin
                next_state = (rcv_data == SYNC_BYTE) ? DATA_RX : ERR_WAIT;
            end
            DATA_RX: begin
                // eop on a byte boundary is a clean end; anywhere else it truncates a byte
                if (shift_enable && eop)
                    next_state = (bit_cnt == 3'd0) ? EOP_WAIT : ERR_EOP;
                else if (shift_enable && bit_cnt == 3'd7)
                    next_state = (byte_cnt == MAX_CNT) ? ERR_WAIT : STORE;
            end
            STORE: begin
                next_state = DATA_RX;
            end
            EOP_WAIT: begin
                if (d_edge)
                    next_state = IDLE;
            end
            ERR_WAIT: begin
                if (shift_enable && eop)
                    next_state = ERR_EOP;
            end
            ERR_EOP: begin
                if (d_edge)
                    next_state = EIDLE;
            end
            EIDLE: begin
                if (d_edge) begin
                    next_state = SYNC_RX;
                    pkt_start  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign counting = shift_enable && (state == SYNC_RX || state == DATA_RX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= 3'd0;
        end else if (pkt_start) begin
            bit_cnt <= 3'd0;
        end else if (counting) begin
            bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
        end
    end

    // STORE is only reachable below MAX_CNT, so the counter cannot wrap
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_cnt <= '0;
        end else if (pkt_start) begin
            byte_cnt <= '0;
        end else if (state == STORE) begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    always_comb begin
        rcving   = 1'b0;
        w_enable = 1'b0;
        r_error  = 1'b0;
        case (state)
            SYNC_RX, SYNC_CHK, DATA_RX, EOP_WAIT: rcving = 1'b1;
            STORE: begin
                rcving   = 1'b1;
                w_enable = 1'b1;
            end
            ERR_WAIT, ERR_EOP: begin
                rcving  = 1'b1;
                r_error = 1'b1;
            end
            EIDLE:   r_error = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Directed bench for usb_rcv_ctrl: a default instance (64 bytes) and a MAX_BYTES=2
// instance share the stimulus so overrun can be contrasted against a normal store.
module tb_usb_rcv_ctrl;

    logic       clk;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic [7:0] rcv_data;

    logic       a_rcving, a_wen, a_err;
    logic [6:0] a_cnt;
    logic [3:0] a_state;
    logic       b_rcving, b_wen, b_err;
    logic [1:0] b_cnt;
    logic [3:0] b_state;

    int n_chk;
    int n_fail;
    int wa;
    int wb;
    int wa0;
    int wb0;

    usb_rcv_ctrl dut_a (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .rcv_data(rcv_data),
        .rcving(a_rcving), .w_enable(a_wen), .r_error(a_err),
        .byte_cnt(a_cnt), .state_dbg(a_state)
    );

    usb_rcv_ctrl #(.MAX_BYTES(2)) dut_b (
        .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
        .shift_enable(shift_enable), .rcv_data(rcv_data),
        .rcving(b_rcving), .w_enable(b_wen), .r_error(b_err),
        .byte_cnt(b_cnt), .state_dbg(b_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write-strobe scoreboard: counts FIFO writes seen at each active edge
    always @(posedge clk) begin
        if (a_wen) wa++;
        if (b_wen) wb++;
    end

    typedef struct {
        int         n;
        logic       de;
        logic       e;
        logic       se;
        logic [7:0] d;
        logic       r;
        logic       w;
        logic       er;
        logic [6:0] c;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // drive one cycle of inputs, then sample #1 after the edge that consumed them
    task automatic step(input logic de, input logic e, input logic se, input logic [7:0] d);
        d_edge       = de;
        eop          = e;
        shift_enable = se;
        rcv_data     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_ok();
        repeat (8) step(1'b0, 1'b0, 1'b1, 8'h80);
        step(1'b0, 1'b0, 1'b0, 8'h80);
    endtask

    task automatic send_byte(input logic [7:0] d);
        repeat (8) step(1'b0, 1'b0, 1'b1, d);
        step(1'b0, 1'b0, 1'b0, d);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; wa = 0; wb = 0;
        n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0; rcv_data = 8'h00;

        //                n de e se data   r w er c
        tbl[0]  = '{1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0};
        tbl[1]  = '{7, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 7'd0};
        tbl[2]  = '{1, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 7'd0};
        tbl[3]  = '{1, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 7'd0};
        tbl[4]  = '{1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 7'd0};
        tbl[5]  = '{7, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 7'd0};
        tbl[6]  = '{1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 7'd0};
        tbl[7]  = '{1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 7'd1};
        tbl[8]  = '{7, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 7'd1};
        tbl[9]  = '{1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 7'd1};
        tbl[10] = '{1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 7'd2};
        tbl[11] = '{1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 7'd2};
        tbl[12] = '{2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd2};
        tbl[13] = '{1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd2};
        tbl[14] = '{2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd2};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rcving", a_rcving, 1'b0);
        chk("rst_wen", a_wen, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_cnt", a_cnt, 7'd0);
        chk("rst_state", a_state, 4'd0);
        n_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("idle_hold", a_rcving, 1'b0);

        // good packet: SYNC + A5 + 3C + clean eop + closing edge
        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step(tbl[i].de, tbl[i].e, tbl[i].se, tbl[i].d);
                chk($sformatf("good%0d_rcving", i), a_rcving, tbl[i].r);
                chk($sformatf("good%0d_wen", i), a_wen, tbl[i].w);
                chk($sformatf("good%0d_err", i), a_err, tbl[i].er);
                chk($sformatf("good%0d_cnt", i), a_cnt, tbl[i].c);
                chk($sformatf("good%0d_b_rcving", i), b_rcving, tbl[i].r);
                chk($sformatf("good%0d_b_cnt", i), {5'd0, b_cnt}, tbl[i].c);
            end
        end
        chk("good_writes", wa, 2);

        // bad SYNC byte
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("bad_cnt_clr", a_cnt, 7'd0);
        repeat (8) step(1'b0, 1'b0, 1'b1, 8'h81);
        step(1'b0, 1'b0, 1'b0, 8'h81);
        chk("bad_err", a_err, 1'b1);
        chk("bad_rcving", a_rcving, 1'b1);
        wa0 = wa;
        repeat (8) step(1'b0, 1'b0, 1'b1, 8'h55);
        chk("bad_no_write", wa, wa0);
        chk("bad_err_hold", a_err, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        chk("bad_erreop_err", a_err, 1'b1);
        chk("bad_erreop_rcving", a_rcving, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("bad_eidle_rcving", a_rcving, 1'b0);
        chk("bad_eidle_err", a_err, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("bad_restart_err", a_err, 1'b0);
        chk("bad_restart_rcving", a_rcving, 1'b1);

        // partial byte: eop after 3 data bits
        sync_ok();
        repeat (3) step(1'b0, 1'b0, 1'b1, 8'hAA);
        step(1'b0, 1'b1, 1'b1, 8'hAA);
        chk("part_err", a_err, 1'b1);
        chk("part_cnt", a_cnt, 7'd0);
        chk("part_wen", a_wen, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("part_eidle", a_rcving, 1'b0);

        // asynchronous reset in the middle of a byte
        step(1'b1, 1'b0, 1'b0, 8'h00);
        sync_ok();
        send_byte(8'h11);
        chk("mid_cnt1", a_cnt, 7'd1);
        repeat (5) step(1'b0, 1'b0, 1'b1, 8'h22);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_rcving", a_rcving, 1'b0);
        chk("mid_rst_wen", a_wen, 1'b0);
        chk("mid_rst_err", a_err, 1'b0);
        chk("mid_rst_cnt", a_cnt, 7'd0);
        chk("mid_rst_state", a_state, 4'd0);
        wa0 = wa;
        repeat (3) step(1'b0, 1'b0, 1'b1, 8'h22);
        chk("mid_rst_no_write", wa, wa0);
        n_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_rst_idle", a_rcving, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("post_rst_start", a_rcving, 1'b1);

        // overrun: three payload bytes; dut_b allows only two
        wa0 = wa;
        wb0 = wb;
        sync_ok();
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (8) step(1'b0, 1'b0, 1'b1, 8'h03);
        chk("ovr_b_err", b_err, 1'b1);
        chk("ovr_b_wen", b_wen, 1'b0);
        chk("ovr_b_rcving", b_rcving, 1'b1);
        chk("ovr_a_wen", a_wen, 1'b1);
        chk("ovr_a_err", a_err, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h03);
        chk("ovr_a_cnt", a_cnt, 7'd3);
        chk("ovr_b_cnt", b_cnt, 2'd2);
        chk("ovr_a_writes", wa - wa0, 3);
        chk("ovr_b_writes", wb - wb0, 2);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        chk("ovr_a_clean_end", a_err, 1'b0);
        chk("ovr_b_erreop", b_err, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ovr_a_idle", a_rcving, 1'b0);
        chk("ovr_b_eidle_rcving", b_rcving, 1'b0);
        chk("ovr_b_eidle_err", b_err, 1'b1);
        chk("ovr_b_cnt_hold", b_cnt, 2'd2);

        // eop during SYNC at bit 4
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("se_b_err_clr", b_err, 1'b0);
        chk("se_b_cnt_clr", b_cnt, 2'd0);
        repeat (4) step(1'b0, 1'b0, 1'b1, 8'h80);
        chk("se_pre_err", a_err, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h80);
        chk("se_err", a_err, 1'b1);
        chk("se_rcving", a_rcving, 1'b1);
        chk("se_b_err", b_err, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("se_eidle_rcving", a_rcving, 1'b0);
        chk("se_eidle_err", a_err, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("se_eidle_hold", a_err, 1'b1);
        chk("se_eidle_state", a_state, 4'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
